// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART receiver and its FIFO.
package uart_pkg;

  localparam int unsigned ENTRY_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  function automatic logic [3:0] word_len(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

  // Unused data MSBs are zero, so reducing the full byte is safe for short words.
  function automatic logic parity_expected(input logic [7:0] data, input logic eps,
                                           input logic sticky);
    return sticky ? ~eps : ((^data) ^ ~eps);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through receive FIFO with sticky overrun flag.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ENTRY_W-1:0]    wr_data,
  input  logic                  rd_en,
  output logic [ENTRY_W-1:0]    rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overrun
);

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc, ovr_set;

  assign empty   = (count == '0);
  assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign rd_acc  = rd_en && !empty;
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign wr_acc  = wr_en && (!full || rd_en);
  assign ovr_set = wr_en && !wr_acc;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovr_set)     overrun <= 1'b1;
      else if (rd_acc) overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: majority-voted bit sampling, parity/frame/break
// detection, and a FWFT receive FIFO.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 6,
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                rxd_i,
  input  logic                parity_en,
  input  logic                eps,
  input  logic                sticky_parity,
  input  logic                stop_bit,
  input  logic [1:0]          wls,
  input  logic                rd_en,
  output logic [7:0]          rx_data_o,
  output logic                parity_error,
  output logic                frame_error,
  output logic                rx_empty,
  output logic                rx_full,
  output logic [ADDR_WIDTH:0] rx_count,
  output logic                rx_done,
  output logic                break_det,
  output logic                overrun
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(OVERSAMPLE);
  localparam logic [BW-1:0] POS_S0   = BW'(OVERSAMPLE/2 - 1);
  localparam logic [BW-1:0] POS_S1   = BW'(OVERSAMPLE/2);
  localparam logic [BW-1:0] POS_S2   = BW'(OVERSAMPLE/2 + 1);
  localparam logic [BW-1:0] POS_LAST = BW'(OVERSAMPLE - 1);

  rx_state_e            state, state_nx;
  logic                 sync1, rxd_s;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic [BW-1:0]        bit_tick, pos;
  logic                 s0, s1, maj, decide;
  logic [7:0]           data_q;
  logic [2:0]           bit_cnt;
  logic                 stop_cnt;
  logic [1:0]           wls_q;
  logic                 par_en_q, eps_q, sticky_q, stop_bit_q;
  logic                 pe_q, fe_q, zero_q;
  logic                 start_go, frame_end, is_break, fe_final, wr_en;
  logic [3:0]           last_bit;
  logic [ENTRY_W-1:0]   head;

  assign tick     = (tick_cnt == TW'(CLK_DIV - 1));
  assign pos      = (bit_tick == POS_LAST) ? '0 : bit_tick + 1'b1;
  assign maj      = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);
  assign decide   = tick && (pos == POS_S2);
  assign last_bit = word_len(wls_q) - 4'd1;
  assign fe_final = fe_q | ~maj;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      rxd_s    <= 1'b1;
      tick_cnt <= '0;
      state    <= IDLE;
    end else begin
      sync1    <= rxd_i;
      rxd_s    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      state    <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    start_go  = 1'b0;
    frame_end = 1'b0;
    is_break  = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE:      if (tick && !rxd_s) begin
                   state_nx = START;
                   start_go = 1'b1;
                 end
      START:     if (decide) state_nx = maj ? IDLE : DATA;
      DATA:      if (decide && ({1'b0, bit_cnt} == last_bit))
                   state_nx = par_en_q ? PARITY : STOP;
      PARITY:    if (decide) state_nx = STOP;
      STOP:      if (decide && (stop_cnt == stop_bit_q)) begin
                   frame_end = 1'b1;
                   is_break  = zero_q & ~maj;
                   wr_en     = ~is_break;
                   state_nx  = (is_break || fe_final) ? WAIT_HIGH : IDLE;
                 end
      WAIT_HIGH: if (tick && rxd_s) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Bit-tick phase runs continuously across bit boundaries; only start detection re-aligns it.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      bit_tick   <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      data_q     <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      wls_q      <= '0;
      par_en_q   <= 1'b0;
      eps_q      <= 1'b0;
      sticky_q   <= 1'b0;
      stop_bit_q <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      zero_q     <= 1'b0;
      rx_done    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      rx_done   <= frame_end;
      break_det <= is_break;
      if (tick) begin
        bit_tick <= start_go ? '0 : pos;
        if (pos == POS_S0) s0 <= rxd_s;
        if (pos == POS_S1) s1 <= rxd_s;
      end
      if (start_go) begin
        wls_q      <= wls;
        par_en_q   <= parity_en;
        eps_q      <= eps;
        sticky_q   <= sticky_parity;
        stop_bit_q <= stop_bit;
        data_q     <= '0;
        bit_cnt    <= '0;
        stop_cnt   <= 1'b0;
        pe_q       <= 1'b0;
        fe_q       <= 1'b0;
        zero_q     <= 1'b1;
      end
      if (decide) begin
        case (state)
          DATA: begin
            data_q[bit_cnt] <= maj;
            bit_cnt         <= bit_cnt + 1'b1;
            zero_q          <= zero_q & ~maj;
          end
          PARITY: begin
            pe_q   <= (maj != parity_expected(data_q, eps_q, sticky_q));
            zero_q <= zero_q & ~maj;
          end
          STOP: begin
            fe_q     <= fe_final;
            stop_cnt <= 1'b1;
            zero_q   <= zero_q & ~maj;
          end
          default: ;
        endcase
      end
    end
  end

  uart_sync_fifo #(
    .DEPTH(DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .clk     (sys_clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data ({pe_q, fe_final, data_q}),
    .rd_en   (rd_en),
    .rd_data (head),
    .empty   (rx_empty),
    .full    (rx_full),
    .count   (rx_count),
    .overrun (overrun)
  );

  assign rx_data_o    = head[7:0];
  assign frame_error  = head[8];
  assign parity_error = head[9];

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: serial frames in, FIFO heads checked on pop.
module tb_uart_rx_oversampled;
  import uart_pkg::*;

  localparam int BIT_CYC = 96;
  localparam int DEPTH   = 16;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd_i = 1'b1;
  logic       parity_en = 1'b0, eps = 1'b0, sticky_parity = 1'b0, stop_bit = 1'b0;
  logic [1:0] wls = 2'd3;
  logic       rd_en = 1'b0;
  logic [7:0] rx_data_o;
  logic       parity_error, frame_error, rx_empty, rx_full, rx_done, break_det, overrun;
  logic [4:0] rx_count;

  int checks = 0, failures = 0;
  int done_cnt = 0, brk_cnt = 0;
  logic auto_read = 1'b0, pop_one = 1'b0;
  logic [9:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  uart_rx_oversampled #(
    .CLK_DIV(6), .OVERSAMPLE(16), .DEPTH(DEPTH)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .rxd_i(rxd_i), .parity_en(parity_en), .eps(eps),
    .sticky_parity(sticky_parity), .stop_bit(stop_bit), .wls(wls), .rd_en(rd_en),
    .rx_data_o(rx_data_o), .parity_error(parity_error), .frame_error(frame_error),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count), .rx_done(rx_done),
    .break_det(break_det), .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the FIFO head whenever reads are enabled and compares against the scoreboard.
  always @(negedge sys_clk) begin
    if (rx_done) done_cnt++;
    if (break_det) brk_cnt++;
    if (rd_en) rd_en = 1'b0;
    else if ((auto_read || pop_one) && !rx_empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_entry got=%0h exp=none",
                 {parity_error, frame_error, rx_data_o});
      end else begin
        chk("fifo_head", {22'd0, parity_error, frame_error, rx_data_o}, {22'd0, exp_q.pop_front()});
      end
      rd_en   = 1'b1;
      pop_one = 1'b0;
    end
  end

  task automatic set_cfg(input logic [1:0] w, input logic pen, input logic e,
                         input logic st, input logic sb);
    wls = w; parity_en = pen; eps = e; sticky_parity = st; stop_bit = sb;
  endtask

  task automatic drive_bit(input logic v);
    rxd_i = v;
    repeat (BIT_CYC) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input int nstop, input logic last_stop);
    logic [7:0] dv;
    dv = d;
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(dv[i]);
    if (pen) drive_bit(pbit);
    for (int s = 0; s < nstop; s++) drive_bit((s == nstop - 1) ? last_stop : 1'b1);
    drive_bit(1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !rx_empty || rd_en) && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("drain_in_time", {31'd0, n < 3000}, 32'd1);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge sys_clk);
    chk("rst_empty", {31'd0, rx_empty}, 32'd1);
    chk("rst_full", {31'd0, rx_full}, 32'd0);
    chk("rst_count", {27'd0, rx_count}, 32'd0);
    chk("rst_outs", {22'd0, parity_error, frame_error, rx_data_o}, 32'd0);
    chk("rst_flags", {29'd0, rx_done, break_det, overrun}, 32'd0);
    reset = 1'b0;
    repeat (2 * BIT_CYC) @(negedge sys_clk);

    // 8E1 0xA5: four ones, even parity bit 0
    set_cfg(2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    d0 = done_cnt;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1, 1'b1);
    chk("a5_done_once", done_cnt - d0, 32'd1);
    chk("a5_count", {27'd0, rx_count}, 32'd1);
    exp_q.push_back(10'h0A5);
    auto_read = 1'b1;
    wait_drain();

    // 5-bit odd parity, two stops: 0x15 has three ones so parity bit 0
    set_cfg(2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(10'h015);
    send_frame(8'h15, 5, 1'b1, 1'b0, 2, 1'b1);
    exp_q.push_back(10'h115);
    send_frame(8'h15, 5, 1'b1, 1'b0, 2, 1'b0);
    wait_drain();

    // 40-cycle glitch is a false start
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    rxd_i = 1'b0;
    repeat (40) @(negedge sys_clk);
    rxd_i = 1'b1;
    repeat (3 * BIT_CYC) @(negedge sys_clk);
    chk("glitch_no_done", done_cnt - d0, 32'd0);
    chk("glitch_count", {27'd0, rx_count}, 32'd0);
    chk("glitch_idle", {29'd0, dut.state}, {29'd0, IDLE});

    // break: 12 bit times low in 8N1
    d0 = brk_cnt;
    drive_bit(1'b0);
    repeat (11 * BIT_CYC) @(negedge sys_clk);
    rxd_i = 1'b1;
    repeat (2 * BIT_CYC) @(negedge sys_clk);
    chk("break_once", brk_cnt - d0, 32'd1);
    chk("break_no_write", {27'd0, rx_count}, 32'd0);
    exp_q.push_back(10'h03C);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1);
    wait_drain();

    // overflow: DEPTH+1 frames with no reads
    auto_read = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) exp_q.push_back({2'b00, 8'h40 + 8'(i)});
      send_frame(8'h40 + 8'(i), 8, 1'b0, 1'b0, 1, 1'b1);
    end
    chk("ovf_full", {31'd0, rx_full}, 32'd1);
    chk("ovf_overrun", {31'd0, overrun}, 32'd1);
    chk("ovf_count", {27'd0, rx_count}, DEPTH);
    pop_one = 1'b1;
    repeat (4) @(negedge sys_clk);
    chk("ovf_cleared", {31'd0, overrun}, 32'd0);
    chk("ovf_count_after", {27'd0, rx_count}, DEPTH - 1);
    auto_read = 1'b1;
    wait_drain();

    // reset mid-DATA discards everything, including a buffered frame
    auto_read = 1'b0;
    send_frame(8'h77, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("pre_rst_count", {27'd0, rx_count}, 32'd1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rxd_i = 1'b0;
    repeat (BIT_CYC / 2) @(negedge sys_clk);
    reset = 1'b1;
    rxd_i = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("mid_rst_empty", {30'd0, rx_empty, rx_full}, 32'd2);
    chk("mid_rst_count", {27'd0, rx_count}, 32'd0);
    chk("mid_rst_outs", {19'd0, parity_error, frame_error, rx_data_o, rx_done, break_det, overrun}, 32'd0);
    chk("mid_rst_state", {29'd0, dut.state}, {29'd0, IDLE});
    reset = 1'b0;
    repeat (2 * BIT_CYC) @(negedge sys_clk);
    exp_q.push_back(10'h05A);
    auto_read = 1'b1;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
    wait_drain();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
